// File: rtl/bit_pack_8_1.sv
`default_nettype none
// bit_pack_8_1: re-packs the 8:1 mux serial stream (valid/sel/bit) into bytes behind a 2-entry FIFO.
// Optional macro BIT_PACK_STATS_EN adds saturating byte and error counters.
module bit_pack_8_1 #(
   parameter int MSB_FIRST = 0
) (
   input  logic        clk,
   input  logic        async_reset,
   input  logic        valid_i,
   input  logic [2:0]  sel_i,
   input  logic        bit_i,
   output logic [7:0]  word_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        seq_err_o,
   output logic        overflow_o
`ifdef BIT_PACK_STATS_EN
   ,
   output logic [15:0] byte_cnt_o,
   output logic [15:0] err_cnt_o
`endif
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] expected, expected_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [2:0] bit_pos;
   logic [7:0] bit_vec;
   logic       push;
   logic [7:0] push_word;
   logic       seq_err_nxt;

   logic [7:0] mem [0:1];
   logic       rd_ptr, wr_ptr;
   logic [1:0] count;
   logic       pop, full, push_ok, overflow_nxt;

   assign bit_pos = (MSB_FIRST != 0) ? 3'd7 - sel_i : sel_i;
   assign bit_vec = 8'(bit_i) << bit_pos;

   always_comb begin
      state_nxt    = state;
      expected_nxt = expected;
      shreg_nxt    = shreg;
      push         = 1'b0;
      push_word    = 8'h00;
      seq_err_nxt  = 1'b0;
      if (valid_i) begin
         case (state)
            IDLE: begin
               // Beats other than sel 0 are pre-alignment noise and dropped silently.
               if (sel_i == 3'd0) begin
                  shreg_nxt    = bit_vec;
                  expected_nxt = 3'd1;
                  state_nxt    = FILL;
               end
            end
            FILL: begin
               if (sel_i == expected) begin
                  if (sel_i == 3'd7) begin
                     push         = 1'b1;
                     push_word    = shreg | bit_vec;
                     shreg_nxt    = 8'h00;
                     expected_nxt = 3'd0;
                     state_nxt    = IDLE;
                  end else begin
                     shreg_nxt    = shreg | bit_vec;
                     expected_nxt = expected + 3'd1;
                  end
               end else begin
                  seq_err_nxt = 1'b1;
                  if (sel_i == 3'd0) begin
                     shreg_nxt    = bit_vec;
                     expected_nxt = 3'd1;
                  end else begin
                     shreg_nxt    = 8'h00;
                     expected_nxt = 3'd0;
                     state_nxt    = IDLE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state     <= IDLE;
         expected  <= 3'd0;
         shreg     <= 8'h00;
         seq_err_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         expected  <= expected_nxt;
         shreg     <= shreg_nxt;
         seq_err_o <= seq_err_nxt;
      end
   end

   assign valid_o      = (count != 2'd0);
   assign word_o       = valid_o ? mem[rd_ptr] : 8'h00;
   assign pop          = valid_o & ready_i;
   assign full         = (count == 2'd2);
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_ok      = push & (~full | pop);
   assign overflow_nxt = push & full & ~pop;

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         mem[0]     <= 8'h00;
         mem[1]     <= 8'h00;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         count      <= 2'd0;
         overflow_o <= 1'b0;
      end else begin
         overflow_o <= overflow_nxt;
         if (push_ok) begin
            mem[wr_ptr] <= push_word;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef BIT_PACK_STATS_EN
   logic [1:0]  err_inc;
   logic [16:0] err_sum;

   assign err_inc = {1'b0, seq_err_nxt} + {1'b0, overflow_nxt};
   assign err_sum = {1'b0, err_cnt_o} + {15'b0, err_inc};

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         byte_cnt_o <= 16'h0000;
         err_cnt_o  <= 16'h0000;
      end else begin
         if (push_ok && (byte_cnt_o != 16'hFFFF)) begin
            byte_cnt_o <= byte_cnt_o + 16'd1;
         end
         err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_pack_8_1.sv
`default_nettype none
// tb_bit_pack_8_1: directed plus randomized checks of bit_pack_8_1 (both bit orders) against a queue model.
module tb_bit_pack_8_1;

   logic       clk = 1'b0;
   logic       async_reset;
   logic       valid_i, bit_i, ready_i;
   logic [2:0] sel_i;
   logic [7:0] word_a, word_b;
   logic       valid_a, valid_b, serr_a, serr_b, ovf_a, ovf_b;
`ifdef BIT_PACK_STATS_EN
   logic [15:0] bcnt_a, ecnt_a, bcnt_b, ecnt_b;
`endif

   always #5 clk = ~clk;

   bit_pack_8_1 #(.MSB_FIRST(0)) dut_lsb (
      .clk(clk), .async_reset(async_reset), .valid_i(valid_i), .sel_i(sel_i), .bit_i(bit_i),
      .word_o(word_a), .valid_o(valid_a), .ready_i(ready_i), .seq_err_o(serr_a), .overflow_o(ovf_a)
`ifdef BIT_PACK_STATS_EN
      , .byte_cnt_o(bcnt_a), .err_cnt_o(ecnt_a)
`endif
   );

   bit_pack_8_1 #(.MSB_FIRST(1)) dut_msb (
      .clk(clk), .async_reset(async_reset), .valid_i(valid_i), .sel_i(sel_i), .bit_i(bit_i),
      .word_o(word_b), .valid_o(valid_b), .ready_i(ready_i), .seq_err_o(serr_b), .overflow_o(ovf_b)
`ifdef BIT_PACK_STATS_EN
      , .byte_cnt_o(bcnt_b), .err_cnt_o(ecnt_b)
`endif
   );

   int         checks = 0;
   int         errors = 0;

   // Reference model state: collected bits by select index and FIFO contents per bit order.
   bit         in_byte;
   int         exp_sel;
   bit         bits [8];
   logic [7:0] q_lsb [$];
   logic [7:0] q_msb [$];
   bit         m_serr, m_ovf;
   int         m_bcnt, m_ecnt;

   function automatic logic [7:0] pack(bit msb);
      int v = 0;
      for (int i = 0; i < 8; i++)
         if (bits[i]) v += (1 << (msb ? 7 - i : i));
      return 8'(v);
   endfunction

   task automatic start_byte(bit b);
      for (int i = 0; i < 8; i++) bits[i] = 1'b0;
      bits[0] = b;
      in_byte = 1'b1;
      exp_sel = 1;
   endtask

   task automatic model_reset();
      in_byte = 1'b0;
      exp_sel = 0;
      for (int i = 0; i < 8; i++) bits[i] = 1'b0;
      q_lsb.delete();
      q_msb.delete();
      m_serr = 1'b0;
      m_ovf  = 1'b0;
      m_bcnt = 0;
      m_ecnt = 0;
   endtask

   task automatic model_edge();
      bit         pop;
      bit         done;
      logic [7:0] wl, wm;
      pop    = (q_lsb.size() != 0) && ready_i;
      done   = 1'b0;
      wl     = 8'h00;
      wm     = 8'h00;
      m_serr = 1'b0;
      m_ovf  = 1'b0;
      if (valid_i) begin
         if (!in_byte) begin
            if (sel_i == 3'd0) start_byte(bit_i);
         end else if (int'(sel_i) == exp_sel) begin
            bits[sel_i] = bit_i;
            exp_sel++;
            if (sel_i == 3'd7) begin
               done    = 1'b1;
               wl      = pack(1'b0);
               wm      = pack(1'b1);
               in_byte = 1'b0;
            end
         end else begin
            m_serr = 1'b1;
            if (sel_i == 3'd0) start_byte(bit_i);
            else in_byte = 1'b0;
         end
      end
      if (pop) begin
         void'(q_lsb.pop_front());
         void'(q_msb.pop_front());
      end
      if (done) begin
         if (q_lsb.size() < 2) begin
            q_lsb.push_back(wl);
            q_msb.push_back(wm);
            if (m_bcnt < 65535) m_bcnt++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_ecnt = m_ecnt + int'(m_serr) + int'(m_ovf);
      if (m_ecnt > 65535) m_ecnt = 65535;
   endtask

   task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0] el, em;
      el = (q_lsb.size() != 0) ? q_lsb[0] : 8'h00;
      em = (q_msb.size() != 0) ? q_msb[0] : 8'h00;
      check("word_lsb", 16'(word_a), 16'(el));
      check("word_msb", 16'(word_b), 16'(em));
      check("valid_lsb", 16'(valid_a), 16'(q_lsb.size() != 0));
      check("valid_msb", 16'(valid_b), 16'(q_msb.size() != 0));
      check("seq_err_lsb", 16'(serr_a), 16'(m_serr));
      check("seq_err_msb", 16'(serr_b), 16'(m_serr));
      check("overflow_lsb", 16'(ovf_a), 16'(m_ovf));
      check("overflow_msb", 16'(ovf_b), 16'(m_ovf));
`ifdef BIT_PACK_STATS_EN
      check("byte_cnt_lsb", bcnt_a, 16'(m_bcnt));
      check("err_cnt_lsb", ecnt_a, 16'(m_ecnt));
      check("byte_cnt_msb", bcnt_b, 16'(m_bcnt));
      check("err_cnt_msb", ecnt_b, 16'(m_ecnt));
`endif
   endtask

   task automatic cycle(bit v, logic [2:0] s, bit b, bit r);
      valid_i = v;
      sel_i   = s;
      bit_i   = b;
      ready_i = r;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // Bit for select s is val[s], so the LSB-first instance reproduces val.
   task automatic send_byte(logic [7:0] val, bit r);
      for (int s = 0; s < 8; s++) cycle(1'b1, 3'(s), val[s], r);
   endtask

   task automatic do_reset();
      #2;
      async_reset = 1'b1;
      valid_i     = 1'b0;
      #1;
      model_reset();
      check_all();
      check("rst_now_valid", 16'(valid_a), 16'h0);
      check("rst_now_word", 16'(word_a), 16'h0);
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      async_reset = 1'b0;
   endtask

   initial begin
      int nxt;
      bit v;
      logic [2:0] s;

      async_reset = 1'b1;
      valid_i     = 1'b0;
      sel_i       = 3'd0;
      bit_i       = 1'b0;
      ready_i     = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      check("reset_word", 16'(word_a), 16'h0);
      check("reset_valid", 16'(valid_a), 16'h0);
      check("reset_seq_err", 16'(serr_a), 16'h0);
      check("reset_overflow", 16'(ovf_a), 16'h0);
      @(negedge clk);
      async_reset = 1'b0;

      // Aligned byte: bits 1,0,1,1,0,0,1,0 on sel 0..7.
      send_byte(8'h4D, 1'b1);
      check("aligned_lsb_word", 16'(word_a), 16'h4D);
      check("aligned_msb_word", 16'(word_b), 16'hB2);
      check("aligned_valid", 16'(valid_a), 16'h1);
      cycle(1'b0, 3'd0, 1'b0, 1'b1);

      // Misaligned start: sel 3,4 discarded without error.
      cycle(1'b1, 3'd3, 1'b1, 1'b1);
      cycle(1'b1, 3'd4, 1'b1, 1'b1);
      check("misalign_no_err", 16'(serr_a), 16'h0);
      send_byte(8'hFF, 1'b1);
      check("misalign_word", 16'(word_a), 16'hFF);
      cycle(1'b0, 3'd0, 1'b0, 1'b1);

      // Gap in selects: 0,1,2,4 then a clean zero byte.
      cycle(1'b1, 3'd0, 1'b1, 1'b1);
      cycle(1'b1, 3'd1, 1'b1, 1'b1);
      cycle(1'b1, 3'd2, 1'b1, 1'b1);
      cycle(1'b1, 3'd4, 1'b1, 1'b1);
      check("gap_seq_err", 16'(serr_a), 16'h1);
      cycle(1'b0, 3'd0, 1'b0, 1'b1);
      check("gap_err_one_cycle", 16'(serr_a), 16'h0);
      check("gap_no_byte", 16'(valid_a), 16'h0);
      send_byte(8'h00, 1'b1);
      check("gap_zero_valid", 16'(valid_a), 16'h1);
      check("gap_zero_word", 16'(word_a), 16'h00);
      cycle(1'b0, 3'd0, 1'b0, 1'b1);

      // Backpressure from a clean reset: third byte overflows.
      do_reset();
      send_byte(8'hAA, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h0F, 1'b0);
      check("bp_overflow", 16'(ovf_a), 16'h1);
      check("bp_head_held", 16'(word_a), 16'hAA);
`ifdef BIT_PACK_STATS_EN
      check("bp_byte_cnt", bcnt_a, 16'd2);
      check("bp_err_cnt", ecnt_a, 16'd1);
`endif
      cycle(1'b0, 3'd0, 1'b0, 1'b0);
      check("bp_overflow_pulse", 16'(ovf_a), 16'h0);
      check("bp_hold_word", 16'(word_a), 16'hAA);
      cycle(1'b0, 3'd0, 1'b0, 1'b1);
      check("bp_second_word", 16'(word_a), 16'h55);
      cycle(1'b0, 3'd0, 1'b0, 1'b1);
      check("bp_drained", 16'(valid_a), 16'h0);

      // Reset mid-byte with one byte queued.
      send_byte(8'h3C, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 1'b1, 1'b0);
      do_reset();
      for (int i = 4; i < 8; i++) cycle(1'b1, 3'(i), 1'b1, 1'b1);
      check("post_rst_nothing", 16'(valid_a), 16'h0);
      send_byte(8'h96, 1'b1);
      check("post_rst_word", 16'(word_a), 16'h96);
      check("post_rst_msb_word", 16'(word_b), 16'h69);

      // Randomized stream, mostly in order with occasional skips and stalls.
      nxt = 0;
      for (int n = 0; n < 600; n++) begin
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 8) s = 3'(nxt);
         else s = 3'($urandom_range(0, 7));
         if (v) nxt = (int'(s) + 1) % 8;
         cycle(v, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bit_pack_8_1.md
Name: bit_pack_8_1

Overview:
- Sits directly downstream of the 8:1 pipelined bit mux in the channel test path.
- Consumes its serial bit stream (valid, 3-bit select, 1-bit data) and re-packs bits into bytes by select position.
- Checks that selects arrive in order 0..7 and buffers completed bytes in a 2-entry output FIFO with valid/ready handshake toward the byte sink.

Parameters:
- MSB_FIRST, 0, 0: bit with select s lands in word bit s; 1: it lands in word bit 7-s.

Ports:
- clk  in  1  clock, all logic rising-edge.
- async_reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  serial beat valid (from mux valid output).
- sel_i  in  3  select index of the beat (from mux select output).
- bit_i  in  1  serial data bit (from mux data output).
- word_o  out  8  packed byte at FIFO head.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  sink accepts word_o when valid_o && ready_i.
- seq_err_o  out  1  one-cycle pulse on out-of-order select.
- overflow_o  out  1  one-cycle pulse when a completed byte is dropped (FIFO full).

Behaviour:
- Reset (async assert, sync release): state=IDLE, expected select=0, shift register=0, FIFO empty. word_o=0, valid_o=0, seq_err_o=0, overflow_o=0.
- No backpressure on the serial side; every valid_i beat is consumed in its cycle.
- Beats with valid_i=0 are ignored and never change state.
- IDLE:
  - valid_i && sel_i==0: store bit_i; expected=1; go FILL.
  - valid_i && sel_i!=0: discard beat; stay IDLE; no error (pre-alignment).
- FILL:
  - valid_i && sel_i==expected: store bit_i at the mapped position; expected+1.
  - If sel_i==7, the byte is complete: push it to the FIFO, go IDLE, expected=0.
  - valid_i && sel_i!=expected: seq_err_o=1 next cycle; partial byte discarded.
    - If sel_i==0: restart with this bit (expected=1, stay FILL).
    - Otherwise: go IDLE.
- Bit positions not yet written in the current byte hold 0; the shift register is cleared on each byte start.
- Latency: a byte completed by the sel=7 beat at cycle N has valid_o=1 and word_o valid at cycle N+1 (FIFO empty case).
- FIFO: 2 entries, registered outputs. word_o=head entry; word_o is 0 when empty.
  - Pop when valid_o && ready_i.
  - Push when full and no pop that cycle: byte dropped, overflow_o=1 next cycle, FIFO contents unchanged.
  - Push when full with a simultaneous pop: succeeds; no overflow.
  - Push and pop on the same cycle with 1 entry: count stays 1, head advances.
- Handshake: word_o and valid_o hold stable while valid_o && !ready_i.
- Reset asserted mid-byte or with the FIFO occupied: everything clears immediately; any partial byte is lost.
- seq_err_o and overflow_o can pulse in the same cycle; they are independent.

Optional Feature:
- Macro BIT_PACK_STATS_EN.
- When defined, adds outputs:
  - byte_cnt_o [15:0]: counts bytes pushed successfully.
  - err_cnt_o [15:0]: counts seq_err_o pulses plus overflow_o pulses; when both pulse in one cycle it increments by 2.
  - Both counters saturate at 16'hFFFF and clear on async_reset.
- When not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Aligned stream, MSB_FIRST=0: beats sel 0..7 with bits 1,0,1,1,0,0,1,0, ready_i=1 -> word_o=8'h4D with valid_o=1 one cycle after the sel=7 beat; seq_err_o stays 0.
- Same bit sequence with MSB_FIRST=1 -> word_o=8'hB2.
- Misalignment: beats sel 3,4 then sel 0..7 all bits 1 -> first two beats discarded silently, one byte 8'hFF; seq_err_o never asserts.
- Gap: sel 0,1,2,4 -> seq_err_o pulses once after the sel=4 beat, no byte emitted; a following clean sel 0..7 of all-zero bits -> 8'h00.
- Backpressure: ready_i=0, three full bytes AA, 55, 0F -> FIFO holds AA, 55; overflow_o pulses once for 0F. Then raise ready_i -> AA, then 55, then valid_o=0. With BIT_PACK_STATS_EN: byte_cnt_o=2, err_cnt_o=1.
- Reset mid-byte: assert async_reset after sel 0..3 with one byte queued -> valid_o=0 and word_o=0 immediately. After release, sel 4..7 beats produce nothing; a fresh sel 0..7 produces a byte normally.
